shreg_ser_ctrl: RTL and testbench
=================================

Name: shreg_ser_ctrl

Overview:
Transmit controller that sequences a parallel-load shift register as a word serializer. Accepts parallel words over a valid/ready handshake, loads them, and shifts them out one bit per enabled clock with frame markers. Optional inter-word gap and a running word counter. Sits between a word producer (register file or FIFO) and a serial line or downstream bit consumer.

Parameters:
WIDTH, 8, data word width in bits; legal range >= 2.
DIR, "LEFT", "LEFT" = MSB first, shift toward MSB; "RIGHT" = LSB first, shift toward LSB.
IDLE_LEVEL, 1'b1, ser_out level when no bit is valid; also the shift-in fill value.
GAP_CYCLES, 0, idle cycles inserted after each word's last bit; range 0..255.

Ports:
clock  in  1  system clock, rising edge.
aclr  in  1  asynchronous clear, active-high.
enable  in  1  global clock enable; low freezes all state and outputs.
flush  in  1  synchronous abort of the word in flight.
in_valid  in  1  producer has a word.
in_data  in  WIDTH  word to serialize.
in_ready  out  1  controller accepts in_data this cycle.
ser_out  out  1  serial bit.
ser_valid  out  1  ser_out carries a data (or parity) bit.
sof  out  1  first bit of a word.
eof  out  1  last bit of a word.
busy  out  1  state != IDLE.
words_sent  out  16  count of completed words, wraps at 2^16.

Behaviour:
- Reset (aclr high, async): state IDLE, shift reg = 0, bit counter = 0, gap counter = 0, ser_out = IDLE_LEVEL, ser_valid = sof = eof = busy = 0, words_sent = 0.
- Priority per clock: aclr > enable low (hold everything, in_ready = 0) > flush > normal operation.
- in_ready is combinational: enable & !flush & (state == IDLE, or state == SHIFT with last bit and GAP_CYCLES == 0 and parity not compiled in).
- Accept = in_valid & in_ready. The word is loaded on the accepting edge; the first bit appears on ser_out in the following cycle (latency 1). No combinational path from in_data to ser_out.
- FSM:
  IDLE: ser_valid = 0, ser_out = IDLE_LEVEL. Accept -> SHIFT, bit counter = 0.
  SHIFT: ser_out = reg[WIDTH-1] (LEFT) or reg[0] (RIGHT); ser_valid = 1; sof when counter == 0; eof when counter == WIDTH-1. Each enabled cycle shifts by one, filling with IDLE_LEVEL, and increments the counter. At the last bit: next state is PAR if compiled in; else GAP if GAP_CYCLES > 0; else SHIFT if accepting (back-to-back, counter = 0); else IDLE.
  GAP: ser_valid = 0, ser_out = IDLE_LEVEL for exactly GAP_CYCLES enabled cycles, then IDLE.
- words_sent increments on the edge that ends the eof cycle. It does not increment for flushed words.
- Bit counter width is $clog2(WIDTH). Gap counter is 8 bits.
- flush in any state: next state IDLE, counters clear, shift reg = 0, words_sent kept. flush together with in_valid in IDLE drops the word (in_ready = 0).
- enable low mid-word: outputs held at their current values, and the bit stream stretches.

Optional Feature:
SHREG_SER_PARITY_EN.
- Defined: state PAR follows SHIFT and emits one extra bit whose value is the even parity (XOR) of the loaded word. ser_valid = 1 and eof moves to the parity cycle; the data-bit last cycle does not assert eof. in_ready is never high in SHIFT.
- Undefined: no PAR state; the frame is exactly WIDTH bits.

Decomposition:
- Shared package shreg_pkg: state encoding typedef (IDLE, SHIFT, PAR, GAP); DIR string constants; localparam for counter width.
- One sub-module shreg_ser_core: the shift register datapath (load, shift with direction and fill, clear, hold on enable). The controller instantiates it and owns the FSM, counters and handshake.

Test Plan:
- WIDTH=8, LEFT, accept 8'h0F -> ser_out 0,0,0,0,1,1,1,1 on cycles 1-8 after accept; sof on cycle 1, eof on cycle 8; words_sent = 1; in_ready = 0 on cycles 1-7.
- RIGHT, 8'h0F -> ser_out 1,1,1,1,0,0,0,0; ser_out = 1 (IDLE_LEVEL) once idle.
- GAP=0, in_valid held with 8'h0F then 8'hF0 -> 16 contiguous ser_valid cycles; in_ready high only in IDLE and on the first word's eof cycle; words_sent = 2.
- GAP=3 -> 3 cycles ser_valid = 0, ser_out = 1 and in_ready = 0 after eof, then IDLE accepts.
- flush at bit 3 -> next cycle IDLE, ser_valid = 0, words_sent unchanged. enable low 2 cycles at bit 5 -> outputs frozen, eof delayed by 2 cycles.
- aclr mid-word -> immediate reset values. With SHREG_SER_PARITY_EN and 8'h07 -> 9th bit = 1 with eof; with 8'h03 -> 9th bit = 0.

Source files
------------

// File: rtl/shreg_pkg.sv
// shreg_pkg: shared state encoding, direction names and counter sizing for the word serializer.
package shreg_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";
    localparam int    GAP_W     = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shreg_ser_core.sv
// shreg_ser_core: parallel-load shift register with direction, fill value, clear and clock enable.
module shreg_ser_core #(
    parameter int   WIDTH      = 8,
    parameter bit   LEFT       = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;

    assign sr_shifted = LEFT ? {sr[WIDTH-2:0], IDLE_LEVEL} : {IDLE_LEVEL, sr[WIDTH-1:1]};

    always_ff @(posedge clock or posedge aclr)
        if (aclr)
            sr <= '0;
        else if (enable)
            sr <= clear ? '0 : load ? din : shift ? sr_shifted : sr;

    assign dout = LEFT ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/shreg_ser_ctrl.sv
// shreg_ser_ctrl: valid/ready word serializer with sof/eof framing, optional gap and word count.
// Define SHREG_SER_PARITY_EN to append an even-parity bit to every frame.
module shreg_ser_ctrl
    import shreg_pkg::*;
#(
    parameter int    WIDTH      = 8,
    parameter string DIR        = DIR_LEFT,
    parameter logic  IDLE_LEVEL = 1'b1,
    parameter int    GAP_CYCLES = 0
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [15:0]      words_sent
);

`ifdef SHREG_SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CW      = cnt_w(WIDTH);
    localparam bit LEFT    = (DIR != DIR_RIGHT);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam bit B2B     = !HAS_GAP && !PAR_EN;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [GAP_W-1:0] gap, gap_nx;
    logic             last, accept, load, shift, done, dout, par_bit;

    assign last     = (cnt == CW'(WIDTH - 1));
    assign in_ready = enable && !flush && (state == IDLE || (B2B && state == SHIFT && last));
    assign accept   = in_valid && in_ready;

    shreg_ser_core #(
        .WIDTH      (WIDTH),
        .LEFT       (LEFT),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_core (
        .clock  (clock),
        .aclr   (aclr),
        .enable (enable),
        .clear  (flush),
        .load   (load),
        .shift  (shift),
        .din    (in_data),
        .dout   (dout)
    );

`ifdef SHREG_SER_PARITY_EN
    // Parity is captured at load time so the shifted-out register is not needed later.
    always_ff @(posedge clock or posedge aclr)
        if (aclr)
            par_bit <= 1'b0;
        else if (enable && load)
            par_bit <= ^in_data;
`else
    assign par_bit = IDLE_LEVEL;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gap_nx   = gap;
        load     = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            gap_nx   = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    load     = 1'b1;
                end
                SHIFT: begin
                    shift  = 1'b1;
                    load   = accept;
                    cnt_nx = last ? '0 : cnt + 1'b1;
                    done   = last && !PAR_EN;
                    if (last)
                        state_nx = PAR_EN ? PAR : HAS_GAP ? GAP : accept ? SHIFT : IDLE;
                end
                PAR: begin
                    done     = 1'b1;
                    state_nx = HAS_GAP ? GAP : IDLE;
                end
                GAP: begin
                    gap_nx = gap + 1'b1;
                    if (gap == GAP_W'(GAP_CYCLES - 1)) begin
                        state_nx = IDLE;
                        gap_nx   = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge aclr)
        if (aclr) begin
            state      <= IDLE;
            cnt        <= '0;
            gap        <= '0;
            words_sent <= '0;
        end else if (enable) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gap   <= gap_nx;
            if (done)
                words_sent <= words_sent + 1'b1;
        end

    assign ser_valid = (state == SHIFT) || (state == PAR);
    assign ser_out   = (state == SHIFT) ? dout : (state == PAR) ? par_bit : IDLE_LEVEL;
    assign sof       = (state == SHIFT) && (cnt == '0);
    assign eof       = (state == PAR) || ((state == SHIFT) && last && !PAR_EN);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shreg_ser_ctrl.sv
// tb_shreg_ser_ctrl: LEFT/no-gap and RIGHT/gap-3 serializers checked every cycle against expected-bit queues.
module tb_shreg_ser_ctrl;
  localparam int W = 8;
`ifdef SHREG_SER_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif
  logic         clock = 1'b0;
  logic         aclr = 1'b0;
  logic         enable = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  int           total = 0;
  int           bad = 0;
  always #5 clock = ~clock;
  for (genvar c = 0; c < 2; c++) begin : g
    localparam bit LFT = (c == 0);
    localparam int GP  = (c == 0) ? 0 : 3;
    logic        rdy, sv, so, sf, ef, bz;
    logic [15:0] ws;
    logic [2:0]  q[$];
    int          gap_left = 0;
    logic [15:0] words = '0;
    if (c == 0) begin : l
      shreg_ser_ctrl #(.WIDTH(W), .DIR("LEFT"), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) dut (
        .clock(clock), .aclr(aclr), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy),
        .ser_out(so), .ser_valid(sv), .sof(sf), .eof(ef), .busy(bz), .words_sent(ws));
    end else begin : r
      shreg_ser_ctrl #(.WIDTH(W), .DIR("RIGHT"), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) dut (
        .clock(clock), .aclr(aclr), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy),
        .ser_out(so), .ser_valid(sv), .sof(sf), .eof(ef), .busy(bz), .words_sent(ws));
    end
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cfg%0d %s t=%0t got=%0h want=%0h", c, nm, $time, act, exp);
      end
    endtask
    always @(negedge clock) begin
      logic [2:0] h;
      logic       er;
      if (aclr) begin
        q.delete();
        gap_left = 0;
        words = '0;
        chk("rst_valid", 16'(sv), 0);
        chk("rst_out", 16'(so), 1);
        chk("rst_sof", 16'(sf), 0);
        chk("rst_eof", 16'(ef), 0);
        chk("rst_busy", 16'(bz), 0);
        chk("rst_words", ws, 0);
      end else begin
        h  = (q.size() > 0) ? q[0] : 3'b100;
        er = enable && !flush && ((q.size() == 0 && gap_left == 0) ||
                                  (!PB && GP == 0 && q.size() == 1));
        chk("ser_valid", 16'(sv), 16'(q.size() > 0));
        chk("ser_out", 16'(so), 16'(h[2]));
        chk("sof", 16'(sf), 16'(h[1]));
        chk("eof", 16'(ef), 16'(h[0]));
        chk("busy", 16'(bz), 16'(q.size() > 0 || gap_left > 0));
        chk("in_ready", 16'(rdy), 16'(er));
        chk("words_sent", ws, words);
        if (enable) begin
          if (flush) begin
            q.delete();
            gap_left = 0;
          end else begin
            if (q.size() > 0) begin
              h = q.pop_front();
              if (h[0]) begin
                words = words + 16'd1;
                gap_left = GP;
              end
            end else if (gap_left > 0)
              gap_left--;
            if (in_valid && er) begin
              for (int i = 0; i < W; i++) begin
                int k;
                k = LFT ? W - 1 - i : i;
                q.push_back({in_data[k], i == 0, (i == W - 1) && !PB});
              end
              if (PB)
                q.push_back({^in_data, 1'b0, 1'b1});
            end
          end
        end
      end
    end
  end
  task automatic step(input logic en, input logic fl, input logic v, input logic [W-1:0] d);
    @(posedge clock);
    #1;
    enable = en;
    flush = fl;
    in_valid = v;
    in_data = d;
  endtask
  initial begin
    #1 aclr = 1'b1;
    repeat (3) @(posedge clock);
    #1 aclr = 1'b0;
    step(1, 0, 1, 8'h0F);
    for (int i = 0; i < 20; i++) step(1, 0, 1, 8'hF0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 8'h00);
    step(1, 0, 1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h33);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00);
    step(1, 0, 1, 8'h07);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 9) < 7, W'($urandom));
      if (i == 1500) begin
        #2 aclr = 1'b1;
        @(posedge clock);
        #1 aclr = 1'b0;
      end
    end
    step(1, 0, 0, 8'h00);
    repeat (30) @(posedge clock);
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
